// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use stall, branch flush and interrupt entry control for the 5-stage MIPS pipeline (option: PIPE_IRQ_SYNC_EN)
module pipe_hazard_ctrl #(
  parameter logic [31:0] VECTOR = 32'h8000_0004
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        irq,
  input  logic        MemReadEX,
  input  logic [4:0]  rtaddrEX,
  input  logic [4:0]  rsaddrID,
  input  logic [4:0]  rtaddrID,
  input  logic        useRtID,
  input  logic        validID,
  input  logic        branchID,
  input  logic        jumpID,
  input  logic        eretID,
  input  logic [31:0] PCID,
  output logic        stallPC,
  output logic        stallIFID,
  output logic        flushIFID,
  output logic        bubbleIDEX,
  output logic        irq_take,
  output logic [31:0] vec_pc,
  output logic [31:0] epc,
  output logic        kernel,
  output logic [15:0] stall_cnt
);
  typedef enum logic [1:0] {S_RUN, S_WAIT, S_TAKE} state_t;
  state_t state, state_n;
  logic irq_i, hazard, takeable, eret_do;
`ifdef PIPE_IRQ_SYNC_EN
  logic [1:0] irq_sync;
  // two-flop synchronizer for the asynchronous interrupt level
  always_ff @(posedge clk or posedge reset)
    if (reset) irq_sync <= '0;
    else irq_sync <= {irq_sync[0], irq};
  assign irq_i = irq_sync[1];
`else
  assign irq_i = irq;
`endif
  assign hazard = MemReadEX && rtaddrEX != 5'd0 &&
                  (rtaddrEX == rsaddrID || (useRtID && rtaddrEX == rtaddrID));
  assign takeable = validID && !hazard && !branchID && !jumpID && !eretID;
  assign vec_pc = VECTOR;
  // next state and pipeline controls; TAKE and reset leave everything quiet
  always_comb begin
    state_n = state;
    stallPC = 1'b0;
    stallIFID = 1'b0;
    flushIFID = 1'b0;
    bubbleIDEX = 1'b0;
    irq_take = 1'b0;
    eret_do = 1'b0;
    if (!reset)
      case (state)
        S_RUN: begin
          stallPC = hazard;
          stallIFID = hazard;
          bubbleIDEX = hazard;
          flushIFID = (branchID || jumpID || eretID) && !hazard;
          eret_do = eretID && !hazard;
          state_n = (irq_i && !kernel) ? S_WAIT : S_RUN;
        end
        S_WAIT: begin
          stallPC = hazard;
          stallIFID = hazard;
          bubbleIDEX = hazard || takeable;
          irq_take = takeable;
          flushIFID = takeable || ((branchID || jumpID) && !hazard);
          state_n = takeable ? S_TAKE : S_WAIT;
        end
        default: state_n = S_RUN;
      endcase
  end
  // state, exception PC, kernel mode and saturating stall counter
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= S_RUN;
      epc <= '0;
      kernel <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state <= state_n;
      epc <= irq_take ? PCID : epc;
      kernel <= irq_take ? 1'b1 : eret_do ? 1'b0 : kernel;
      stall_cnt <= (stallPC && stall_cnt != 16'hFFFF) ? stall_cnt + 16'd1 : stall_cnt;
    end
endmodule
